apbspi_apb_slave: RTL and testbench

Parametrised APB4 slave protocol engine for the APB-SPI peripheral. It sits between the APB bus and the SPI register bank. It decodes and range-checks each APB access and forwards valid ones as a single-pulse request on a simple register port. It stretches the access phase with `pready` until the register bank acknowledges, and returns `pslverr` for illegal addresses, bank errors and (optionally) timeouts.

---
 rtl/apbspi_apb_slave.sv | 141 ++++++++++++++
 tb/tb_apbspi_apb_slave.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apbspi_apb_slave.sv
// rtl/apbspi_apb_slave.sv - APB4 slave engine forwarding range-checked accesses to the SPI register bank.
// Optional ack timeout is compiled in with `define APBSPI_APB_TIMEOUT_EN.
module apbspi_apb_slave #(
   parameter int                    ADDR_WIDTH     = 32,
   parameter int                    DATA_WIDTH     = 32,
   parameter int                    NUM_REGS       = 16,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = '0,
   parameter int                    TIMEOUT_CYCLES = 16
) (
   input  logic                        pclk,
   input  logic                        presetn,
   input  logic [ADDR_WIDTH-1:0]       paddr,
   input  logic                        psel,
   input  logic                        penable,
   input  logic                        pwrite,
   input  logic [DATA_WIDTH-1:0]       pwdata,
   input  logic [DATA_WIDTH/8-1:0]     pstrb,
   output logic [DATA_WIDTH-1:0]       prdata,
   output logic                        pready,
   output logic                        pslverr,
   output logic                        reg_req,
   output logic                        reg_we,
   output logic [$clog2(NUM_REGS)-1:0] reg_addr,
   output logic [DATA_WIDTH-1:0]       reg_wdata,
   output logic [DATA_WIDTH/8-1:0]     reg_strb,
   input  logic                        reg_ack,
   input  logic [DATA_WIDTH-1:0]       reg_rdata,
   input  logic                        reg_err
);
   localparam int SW    = DATA_WIDTH / 8;
   localparam int RAW   = $clog2(NUM_REGS);
   localparam int SHIFT = $clog2(SW);
   localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(SW - 1);
   localparam logic [ADDR_WIDTH-1:0] NREGS      = ADDR_WIDTH'(NUM_REGS);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;
   state_t state, state_nxt;

   logic [ADDR_WIDTH-1:0] offset, word_idx;
   logic                  setup, legal, timeout;
   logic [DATA_WIDTH-1:0] prdata_nxt, reg_wdata_nxt;
   logic [SW-1:0]         reg_strb_nxt;
   logic [RAW-1:0]        reg_addr_nxt;
   logic                  pready_nxt, pslverr_nxt, reg_req_nxt, reg_we_nxt;

   assign setup    = psel && !penable;
   assign offset   = paddr - BASE_ADDR;
   assign word_idx = offset >> SHIFT;
   assign legal    = (paddr >= BASE_ADDR) && ((offset & ALIGN_MASK) == '0) && (word_idx < NREGS);

`ifdef APBSPI_APB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES);
   logic [CW-1:0] wait_cnt;

   // Counter value equals the number of ack-less WAIT cycles already completed.
   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn)              wait_cnt <= '0;
      else if (state != S_WAIT)  wait_cnt <= '0;
      else if (!reg_ack)         wait_cnt <= wait_cnt + CW'(1);
   end
   assign timeout = (state == S_WAIT) && !reg_ack && (wait_cnt == CW'(TIMEOUT_CYCLES - 1));
`else
   assign timeout = 1'b0;
`endif

   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         state     <= S_IDLE;
         prdata    <= '0;
         pready    <= 1'b0;
         pslverr   <= 1'b0;
         reg_req   <= 1'b0;
         reg_we    <= 1'b0;
         reg_addr  <= '0;
         reg_wdata <= '0;
         reg_strb  <= '0;
      end else begin
         state     <= state_nxt;
         prdata    <= prdata_nxt;
         pready    <= pready_nxt;
         pslverr   <= pslverr_nxt;
         reg_req   <= reg_req_nxt;
         reg_we    <= reg_we_nxt;
         reg_addr  <= reg_addr_nxt;
         reg_wdata <= reg_wdata_nxt;
         reg_strb  <= reg_strb_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: if (setup) state_nxt = legal ? S_WAIT : S_DONE;
         S_WAIT: begin
            if (!psel)                   state_nxt = S_IDLE;
            else if (reg_ack || timeout) state_nxt = S_DONE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // Outputs are registered, so this computes their values for the next cycle.
   always_comb begin
      prdata_nxt    = prdata;
      pready_nxt    = 1'b0;
      pslverr_nxt   = 1'b0;
      reg_req_nxt   = 1'b0;
      reg_we_nxt    = reg_we;
      reg_addr_nxt  = reg_addr;
      reg_wdata_nxt = reg_wdata;
      reg_strb_nxt  = reg_strb;
      case (state)
         S_IDLE: begin
            if (setup && legal) begin
               reg_req_nxt   = 1'b1;
               reg_we_nxt    = pwrite;
               reg_addr_nxt  = word_idx[RAW-1:0];
               reg_wdata_nxt = pwdata;
               reg_strb_nxt  = pwrite ? pstrb : '0;
            end else if (setup) begin
               pready_nxt  = 1'b1;
               pslverr_nxt = 1'b1;
               prdata_nxt  = '0;
            end
         end
         S_WAIT: begin
            if (psel && reg_ack) begin
               pready_nxt  = 1'b1;
               pslverr_nxt = reg_err;
               if (reg_err)      prdata_nxt = '0;
               else if (!reg_we) prdata_nxt = reg_rdata;
            end else if (psel && timeout) begin
               pready_nxt  = 1'b1;
               pslverr_nxt = 1'b1;
               prdata_nxt  = '0;
            end
         end
         default: ;
      endcase
   end
endmodule

// File: tb/tb_apbspi_apb_slave.sv
// tb/tb_apbspi_apb_slave.sv - Self-checking bench for apbspi_apb_slave against a transaction-level model.
module tb_apbspi_apb_slave;
   localparam logic [31:0] BASE = 32'h0000_1000;

   logic        pclk = 1'b0;
   logic        presetn;
   logic [31:0] paddr;
   logic        psel, penable, pwrite;
   logic [31:0] pwdata;
   logic [3:0]  pstrb;
   logic [31:0] prdata;
   logic        pready, pslverr, reg_req, reg_we;
   logic [3:0]  reg_addr;
   logic [31:0] reg_wdata;
   logic [3:0]  reg_strb;
   logic        reg_ack;
   logic [31:0] reg_rdata;
   logic        reg_err;

   int checks = 0;
   int errors = 0;

   int          o_ready_cycle, o_req_count, o_req_cycle;
   logic        o_slverr, o_we;
   logic [31:0] o_prdata, o_wdata;
   logic [3:0]  o_addr, o_strb;
   logic [31:0] exp_prdata;

   apbspi_apb_slave #(
      .ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_REGS(16), .BASE_ADDR(BASE), .TIMEOUT_CYCLES(16)
   ) dut (
      .pclk(pclk), .presetn(presetn), .paddr(paddr), .psel(psel), .penable(penable),
      .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb), .prdata(prdata), .pready(pready),
      .pslverr(pslverr), .reg_req(reg_req), .reg_we(reg_we), .reg_addr(reg_addr),
      .reg_wdata(reg_wdata), .reg_strb(reg_strb), .reg_ack(reg_ack), .reg_rdata(reg_rdata),
      .reg_err(reg_err)
   );

   always #5 pclk = ~pclk;

   function automatic logic legal_ref(input logic [31:0] addr);
      longint off;
      if (addr < BASE) return 1'b0;
      off = longint'(addr) - longint'(BASE);
      return (off % 4 == 0) && (off / 4 < 16);
   endfunction

   // Acts as APB master and register bank for one transfer; ack_at is the access cycle carrying reg_ack.
   task automatic do_xfer(input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                          input logic [3:0] strb, input int ack_at, input logic [31:0] bank_rdata,
                          input logic bank_err, input int max_cycles);
      o_ready_cycle = 0; o_req_count = 0; o_req_cycle = 0; o_slverr = 1'b0; o_prdata = '0;
      paddr = addr; pwrite = wr; pwdata = wdata; pstrb = strb; psel = 1'b1; penable = 1'b0;
      for (int c = 1; c <= max_cycles; c++) begin
         @(posedge pclk); #1;
         penable = 1'b1;
         reg_ack = (c == ack_at); reg_rdata = bank_rdata; reg_err = bank_err;
         @(negedge pclk);
         if (reg_req) begin
            o_req_count++; o_req_cycle = c;
            o_we = reg_we; o_addr = reg_addr; o_strb = reg_strb; o_wdata = reg_wdata;
         end
         if (pready) begin
            o_ready_cycle = c; o_slverr = pslverr; o_prdata = prdata;
            break;
         end
      end
      @(posedge pclk); #1;
      psel = 1'b0; penable = 1'b0; reg_ack = 1'b0; reg_err = 1'b0;
   endtask

   task automatic test_reset();
      presetn = 1'b0;
      repeat (2) @(posedge pclk);
      @(negedge pclk);
      checks++;
      if ({prdata, pready, pslverr, reg_req, reg_we, reg_addr, reg_wdata, reg_strb} !== '0) begin
         errors++; $display("FAIL reset_outputs got prdata=%h pready=%b pslverr=%b req=%b expected all zero", prdata, pready, pslverr, reg_req);
      end
      @(posedge pclk); #1;
      presetn = 1'b1;
      exp_prdata = '0;
   endtask

   task automatic test_read_reg3();
      do_xfer(BASE + 32'd12, 1'b0, 32'h1111_2222, 4'hF, 1, 32'hA5A5_1234, 1'b0, 10);
      exp_prdata = 32'hA5A5_1234;
      checks++;
      if (o_req_count !== 1 || o_req_cycle !== 1 || o_addr !== 4'd3 || o_strb !== 4'h0 || o_we !== 1'b0) begin
         errors++; $display("FAIL read3_req got cnt=%0d cyc=%0d addr=%0d strb=%h we=%b expected 1 1 3 0 0", o_req_count, o_req_cycle, o_addr, o_strb, o_we);
      end
      checks++;
      if (o_ready_cycle !== 2 || o_slverr !== 1'b0) begin
         errors++; $display("FAIL read3_ready got cyc=%0d err=%b expected 2 0", o_ready_cycle, o_slverr);
      end
      checks++;
      if (o_prdata !== exp_prdata) begin
         errors++; $display("FAIL read3_prdata got %h expected %h", o_prdata, exp_prdata);
      end
   endtask

   task automatic test_write_delayed();
      do_xfer(BASE, 1'b1, 32'hDEAD_BEEF, 4'b0101, 4, 32'h5555_5555, 1'b0, 10);
      checks++;
      if (o_req_count !== 1 || o_we !== 1'b1 || o_strb !== 4'b0101 || o_addr !== 4'd0 || o_wdata !== 32'hDEAD_BEEF) begin
         errors++; $display("FAIL write_req got cnt=%0d we=%b strb=%b addr=%0d wdata=%h", o_req_count, o_we, o_strb, o_addr, o_wdata);
      end
      checks++;
      if (o_ready_cycle !== 5 || o_slverr !== 1'b0) begin
         errors++; $display("FAIL write_ready got cyc=%0d err=%b expected 5 0", o_ready_cycle, o_slverr);
      end
      checks++;
      if (o_prdata !== exp_prdata) begin
         errors++; $display("FAIL write_prdata_hold got %h expected %h", o_prdata, exp_prdata);
      end
   endtask

   task automatic test_illegal();
      logic [31:0] addrs [3];
      addrs[0] = BASE + 32'h42; addrs[1] = BASE + 32'd64; addrs[2] = BASE - 32'd4;
      for (int i = 0; i < 3; i++) begin
         do_xfer(addrs[i], 1'b0, 32'h0, 4'h0, 1, 32'hFFFF_FFFF, 1'b0, 5);
         exp_prdata = '0;
         checks++;
         if (o_req_count !== 0 || o_ready_cycle !== 1 || o_slverr !== 1'b1 || o_prdata !== exp_prdata) begin
            errors++; $display("FAIL illegal_%0d got req=%0d cyc=%0d err=%b prdata=%h expected 0 1 1 0", i, o_req_count, o_ready_cycle, o_slverr, o_prdata);
         end
      end
   endtask

   task automatic test_bank_err();
      do_xfer(BASE + 32'd20, 1'b0, 32'h0, 4'h0, 1, 32'h1234_5678, 1'b0, 5);
      do_xfer(BASE + 32'd24, 1'b0, 32'h0, 4'h0, 2, 32'h9999_8888, 1'b1, 6);
      exp_prdata = '0;
      checks++;
      if (o_ready_cycle !== 3 || o_slverr !== 1'b1 || o_prdata !== exp_prdata) begin
         errors++; $display("FAIL bank_err got cyc=%0d err=%b prdata=%h expected 3 1 0", o_ready_cycle, o_slverr, o_prdata);
      end
   endtask

   task automatic test_psel_drop();
      do_xfer(BASE + 32'd4, 1'b0, 32'h0, 4'h0, 0, 32'h0, 1'b0, 3);
      checks++;
      if (o_ready_cycle !== 0) begin
         errors++; $display("FAIL psel_drop_noready got cyc=%0d expected 0", o_ready_cycle);
      end
      reg_ack = 1'b1; reg_rdata = 32'hCAFE_CAFE;
      for (int i = 0; i < 3; i++) begin
         @(negedge pclk);
         checks++;
         if (pready !== 1'b0 || reg_req !== 1'b0 || prdata !== exp_prdata) begin
            errors++; $display("FAIL psel_drop_late_ack got pready=%b req=%b prdata=%h expected 0 0 %h", pready, reg_req, prdata, exp_prdata);
         end
         @(posedge pclk); #1;
      end
      reg_ack = 1'b0;
   endtask

`ifdef APBSPI_APB_TIMEOUT_EN
   task automatic test_timeout();
      do_xfer(BASE + 32'd8, 1'b0, 32'h0, 4'h0, 0, 32'h7777_7777, 1'b0, 20);
      exp_prdata = '0;
      checks++;
      if (o_ready_cycle !== 17 || o_slverr !== 1'b1 || o_prdata !== exp_prdata) begin
         errors++; $display("FAIL timeout got cyc=%0d err=%b prdata=%h expected 17 1 0", o_ready_cycle, o_slverr, o_prdata);
      end
      reg_ack = 1'b1; reg_rdata = 32'h7777_7777;
      for (int i = 0; i < 3; i++) begin
         @(negedge pclk);
         checks++;
         if (pready !== 1'b0 || prdata !== exp_prdata) begin
            errors++; $display("FAIL timeout_late_ack got pready=%b prdata=%h expected 0 0", pready, prdata);
         end
         @(posedge pclk); #1;
      end
      reg_ack = 1'b0;
      do_xfer(BASE + 32'd8, 1'b0, 32'h0, 4'h0, 16, 32'h0BAD_F00D, 1'b0, 20);
      exp_prdata = 32'h0BAD_F00D;
      checks++;
      if (o_ready_cycle !== 17 || o_slverr !== 1'b0 || o_prdata !== exp_prdata) begin
         errors++; $display("FAIL timeout_ack_wins got cyc=%0d err=%b prdata=%h expected 17 0 %h", o_ready_cycle, o_slverr, o_prdata, exp_prdata);
      end
   endtask
`else
   task automatic test_no_timeout();
      do_xfer(BASE + 32'd8, 1'b0, 32'h0, 4'h0, 0, 32'h0, 1'b0, 100);
      checks++;
      if (o_ready_cycle !== 0) begin
         errors++; $display("FAIL no_timeout got pready in cycle %0d expected none in 100", o_ready_cycle);
      end
      repeat (2) @(posedge pclk);
      #1;
   endtask
`endif

   task automatic test_reset_mid_wait();
      paddr = BASE + 32'd8; pwrite = 1'b0; psel = 1'b1; penable = 1'b0;
      @(posedge pclk); #1; penable = 1'b1;
      repeat (3) @(posedge pclk);
      #2;
      reg_ack = 1'b1; reg_rdata = 32'h3333_4444;
      presetn = 1'b0;
      #1;
      exp_prdata = '0;
      checks++;
      if ({prdata, pready, pslverr, reg_req, reg_we, reg_addr, reg_wdata, reg_strb} !== '0) begin
         errors++; $display("FAIL reset_mid_wait got prdata=%h pready=%b pslverr=%b req=%b expected all zero", prdata, pready, pslverr, reg_req);
      end
      @(posedge pclk); #1;
      presetn = 1'b1; psel = 1'b0; penable = 1'b0;
      @(negedge pclk);
      checks++;
      if (pready !== 1'b0 || reg_req !== 1'b0) begin
         errors++; $display("FAIL reset_ack_discard got pready=%b req=%b expected 0 0", pready, reg_req);
      end
      @(posedge pclk); #1; reg_ack = 1'b0;
      do_xfer(BASE + 32'd28, 1'b0, 32'h0, 4'h0, 1, 32'h0101_0101, 1'b0, 5);
      checks++;
      if (o_ready_cycle !== 2 || o_prdata !== 32'h0101_0101) begin
         errors++; $display("FAIL b2b_first got cyc=%0d prdata=%h expected 2 01010101", o_ready_cycle, o_prdata);
      end
      do_xfer(BASE + 32'd32, 1'b0, 32'h0, 4'h0, 1, 32'h0202_0202, 1'b0, 5);
      exp_prdata = 32'h0202_0202;
      checks++;
      if (o_ready_cycle !== 2 || o_prdata !== exp_prdata || o_addr !== 4'd8) begin
         errors++; $display("FAIL b2b_second got cyc=%0d prdata=%h addr=%0d expected 2 %h 8", o_ready_cycle, o_prdata, o_addr, exp_prdata);
      end
   endtask

   task automatic test_random();
      for (int n = 0; n < 60; n++) begin
         logic [31:0] addr, wdata, rdata;
         logic        wr, err, lg;
         logic [3:0]  strb;
         int          kind, ack_at, exp_cyc;
         kind = $urandom_range(0, 3);
         case (kind)
            0:       addr = BASE + 32'(4 * $urandom_range(0, 15));
            1:       addr = BASE + 32'(4 * $urandom_range(0, 15) + $urandom_range(1, 3));
            2:       addr = BASE + 32'd64 + 32'(4 * $urandom_range(0, 100));
            default: addr = 32'($urandom_range(0, 32'(BASE) - 1));
         endcase
         wr = 1'($urandom_range(0, 1)); strb = 4'($urandom_range(0, 15));
         wdata = $urandom; rdata = $urandom;
         err = ($urandom_range(0, 3) == 0); ack_at = $urandom_range(1, 5);
         lg = legal_ref(addr);
         do_xfer(addr, wr, wdata, strb, ack_at, rdata, err, 10);
         exp_cyc = lg ? ack_at + 1 : 1;
         if (!lg || err)  exp_prdata = '0;
         else if (!wr)    exp_prdata = rdata;
         checks++;
         if (o_ready_cycle !== exp_cyc || o_slverr !== (!lg || err) || o_prdata !== exp_prdata) begin
            errors++; $display("FAIL rand_%0d_resp addr=%h got cyc=%0d err=%b prdata=%h expected %0d %b %h", n, addr, o_ready_cycle, o_slverr, o_prdata, exp_cyc, (!lg || err), exp_prdata);
         end
         checks++;
         if (o_req_count !== (lg ? 1 : 0)) begin
            errors++; $display("FAIL rand_%0d_reqcount addr=%h got %0d expected %0d", n, addr, o_req_count, lg ? 1 : 0);
         end
         if (lg) begin
            checks++;
            if (o_req_cycle !== 1 || o_we !== wr || o_addr !== 4'((addr - BASE) / 4) ||
                o_strb !== (wr ? strb : 4'h0) || o_wdata !== wdata) begin
               errors++; $display("FAIL rand_%0d_fields got we=%b addr=%0d strb=%h wdata=%h expected %b %0d %h %h", n, o_we, o_addr, o_strb, o_wdata, wr, (addr - BASE) / 4, wr ? strb : 4'h0, wdata);
            end
         end
      end
   endtask

   initial begin
      paddr = '0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; pwdata = '0; pstrb = '0;
      reg_ack = 1'b0; reg_rdata = '0; reg_err = 1'b0;
      o_we = 1'b0; o_addr = '0; o_strb = '0; o_wdata = '0;
      test_reset();
      test_read_reg3();
      test_write_delayed();
      test_illegal();
      test_bank_err();
      test_psel_drop();
`ifdef APBSPI_APB_TIMEOUT_EN
      test_timeout();
`else
      test_no_timeout();
`endif
      test_reset_mid_wait();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
